shift_arbiter: RTL and testbench

Sequencing and sharing controller for the 16-bit shift resource of the ALU. Two requesters, such as the issue stage and a multi-cycle microcode path, present an operand and a 5-bit signed shift immediate. The block grants one requester at a time using round-robin priority and performs the shift iteratively, at most `STEP` bits per cycle. It returns the result through a valid/ready response port tagged with the requester id.

---
 rtl/shift_arbiter.sv | 123 ++++++++++++
 tb/tb_shift_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter for two requesters sharing an iterative 16-bit shifter.
// Each command carries an operand and a 5-bit signed shift amount. A non-negative amount
// shifts left and a negative amount shifts logical right. The shift is applied at most STEP
// bits per cycle. The result is returned on a valid/ready port, tagged with the requester id.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req{0,1}_valid/_ready       command handshake per requester
//   req{0,1}_data[15:0]         operand
//   req{0,1}_imm[4:0]           signed shift amount (two's complement)
//   rsp_valid/rsp_ready         result handshake
//   rsp_data[15:0], rsp_id      result and originating requester
//   busy                        high while shifting or holding a result
module shift_arbiter #(
  parameter int unsigned STEP = 1  // 1, 2, 4, 8 or 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_data,
  input  logic [4:0]  req0_imm,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_data,
  input  logic [4:0]  req1_imm,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_id,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StShift, StResp} state_e;

  localparam logic [4:0] StepAmt = 5'(STEP);

  state_e      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [4:0]  rem_q, rem_d;   // remaining magnitude, 0..16
  logic        dir_q, dir_d;   // 1 = right
  logic        id_q, id_d;
  logic        last_q, last_d; // last granted requester

  logic [4:0]  k;
  logic [4:0]  sel_imm;
  logic [15:0] sel_data;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    dir_d      = dir_q;
    id_d       = id_q;
    last_d     = last_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    sel_imm    = req0_imm;
    sel_data   = req0_data;
    // k never exceeds rem, so rem cannot underflow.
    k          = (rem_q < StepAmt) ? rem_q : StepAmt;

    unique case (state_q)
      StIdle: begin
        // Ties go to the requester that was not granted last.
        req0_ready = req0_valid & (~req1_valid | last_q);
        req1_ready = req1_valid & (~req0_valid | ~last_q);
        if (req1_ready) begin
          sel_imm  = req1_imm;
          sel_data = req1_data;
        end
        if (req0_ready || req1_ready) begin
          acc_d  = sel_data;
          dir_d  = sel_imm[4];
          // Negation of 5'b10000 stays 5'b10000, which is the wanted magnitude 16.
          rem_d  = sel_imm[4] ? (~sel_imm + 5'd1) : sel_imm;
          id_d   = req1_ready;
          last_d = req1_ready;
          state_d = (rem_d != 5'd0) ? StShift : StResp;
        end
      end
      StShift: begin
        acc_d = dir_q ? (acc_q >> k) : (acc_q << k);
        rem_d = rem_q - k;
        if (rem_q == k) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= 16'h0000;
      rem_q   <= 5'd0;
      dir_q   <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = acc_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_data, req1_data, rsp_data;
  logic [4:0]  req0_imm, req1_imm;
  logic        rsp_valid, rsp_ready, rsp_id, busy;

  // Second instance with STEP=4; only requester 0 is exercised.
  logic        t4_req0_valid, t4_req0_ready, t4_req1_valid, t4_req1_ready;
  logic [15:0] t4_req0_data, t4_req1_data, t4_rsp_data;
  logic [4:0]  t4_req0_imm, t4_req1_imm;
  logic        t4_rsp_valid, t4_rsp_ready, t4_rsp_id, t4_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit both_seen = 1'b0;

  shift_arbiter #(.STEP(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_imm(req0_imm),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_imm(req1_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy)
  );

  shift_arbiter #(.STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(t4_req0_valid), .req0_ready(t4_req0_ready), .req0_data(t4_req0_data),
    .req0_imm(t4_req0_imm),
    .req1_valid(t4_req1_valid), .req1_ready(t4_req1_ready), .req1_data(t4_req1_data),
    .req1_imm(t4_req1_imm),
    .rsp_valid(t4_rsp_valid), .rsp_ready(t4_rsp_ready), .rsp_data(t4_rsp_data),
    .rsp_id(t4_rsp_id), .busy(t4_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (req0_ready && req1_ready) both_seen = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: presents a command, checks it is accepted this cycle, and returns
  // at the next negedge with valid dropped. acc_cyc is the accept cycle number.
  task automatic issue(input bit which, input logic [15:0] d, input logic [4:0] imm,
                       input string tag, output int acc_cyc);
    if (which) begin
      req1_valid = 1'b1; req1_data = d; req1_imm = imm;
    end else begin
      req0_valid = 1'b1; req0_data = d; req0_imm = imm;
    end
    #1;
    chk({tag, "_ready"}, {31'd0, which ? req1_ready : req0_ready}, 32'd1);
    acc_cyc = cyc;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int acc_cyc, output int lat);
    while (!rsp_valid && (cyc - acc_cyc) < 40) @(negedge clk);
    lat = cyc - acc_cyc;
  endtask

  task automatic run(input bit which, input logic [15:0] d, input logic [4:0] imm,
                     input int exp_lat, input logic [15:0] exp_data, input string tag);
    int a;
    int lat;
    issue(which, d, imm, tag, a);
    wait_rsp(a, lat);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_data"}, {16'd0, rsp_data}, {16'd0, exp_data});
    chk({tag, "_id"}, {31'd0, rsp_id}, {31'd0, which});
    @(negedge clk);
    chk({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int a;
    int lat;
    int n;
    bit bad;
    clk = 1'b0;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_data = 16'h0; req0_imm = 5'd0;
    req1_valid = 1'b0; req1_data = 16'h0; req1_imm = 5'd0;
    rsp_ready = 1'b1;
    t4_req0_valid = 1'b0; t4_req0_data = 16'h0; t4_req0_imm = 5'd0;
    t4_req1_valid = 1'b0; t4_req1_data = 16'h0; t4_req1_imm = 5'd0;
    t4_rsp_ready = 1'b1;

    // Reset values; ready follows the IDLE equation even in reset.
    #2;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_data", {16'd0, rsp_data}, 32'h0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_ready0", {31'd0, req0_ready}, 32'd1);
    chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    run(1'b0, 16'h0001, 5'd3, 4, 16'h0008, "left3");
    run(1'b1, 16'h8000, 5'b10000, 17, 16'h0000, "right16");
    run(1'b1, 16'h8000, 5'b11111, 2, 16'h4000, "right1");
    run(1'b0, 16'hA5A5, 5'd0, 1, 16'hA5A5, "zero");

    // STEP=4: 7 bits in two SHIFT cycles.
    t4_req0_valid = 1'b1; t4_req0_data = 16'h0003; t4_req0_imm = 5'd7;
    #1;
    chk("step4_ready", {31'd0, t4_req0_ready}, 32'd1);
    a = cyc;
    @(negedge clk);
    t4_req0_valid = 1'b0;
    while (!t4_rsp_valid && (cyc - a) < 40) @(negedge clk);
    chk("step4_latency", cyc - a, 3);
    chk("step4_data", {16'd0, t4_rsp_data}, 32'h0180);
    @(negedge clk);

    // Reset in the middle of a shift drops the command.
    issue(1'b1, 16'h8000, 5'b10000, "midrst", a);
    repeat (3) @(negedge clk);
    chk("midrst_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (rsp_valid || busy) bad = 1'b1;
    end
    chk("midrst_no_rsp", {31'd0, bad}, 32'd0);

    // Continuous contention: 0 wins the first tie after reset, then alternation.
    req0_valid = 1'b1; req0_data = 16'h0001; req0_imm = 5'd1;
    req1_valid = 1'b1; req1_data = 16'h0100; req1_imm = 5'b11111;
    both_seen = 1'b0;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      #1;
      while (!(req0_ready || req1_ready) && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("rr_grant1", {31'd0, req1_ready}, g % 2);
      chk("rr_grant0", {31'd0, req0_ready}, 1 - (g % 2));
      a = cyc;
      @(negedge clk);
      wait_rsp(a, lat);
      chk("rr_rsp_id", {31'd0, rsp_id}, g % 2);
      chk("rr_rsp_data", {16'd0, rsp_data}, (g % 2) ? 32'h0080 : 32'h0002);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("rr_never_both_ready", {31'd0, both_seen}, 32'd0);
    @(negedge clk);

    // Stall in RESP with a pending request from requester 1.
    rsp_ready = 1'b0;
    issue(1'b0, 16'h1234, 5'd4, "stall", a);
    wait_rsp(a, lat);
    chk("stall_latency", lat, 5);
    req1_valid = 1'b1; req1_data = 16'h00F0; req1_imm = 5'd0;
    repeat (10) begin
      @(negedge clk);
      #1;
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_data", {16'd0, rsp_data}, 32'h2340);
      chk("stall_id", {31'd0, rsp_id}, 32'd0);
      chk("stall_no_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("release_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("release_accept", {31'd0, req1_ready}, 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    chk("release_rsp_valid2", {31'd0, rsp_valid}, 32'd1);
    chk("release_data", {16'd0, rsp_data}, 32'h00F0);
    chk("release_id", {31'd0, rsp_id}, 32'd1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
